uart_tx_feeder: RTL and testbench
=================================

// Module: uart_tx_feeder
// PURPOSE
//  Upstream stage of the UART transmitter. Buffers host words in a FIFO and feeds them to the transmitter one at a time.
//  Presents each word on DataIn with a one-cycle NewData strobe, then holds it until the transmitter completes.
//  Detects completion from the rising edge of DoneTx and supervises each word with a timeout watchdog.
//  The transmitter handles retransmission itself on Flag_in; this block only waits through retries.
// PARAMETERS
//  SIZE     32    word width; must equal the transmitter's data width
//  DEPTH    8     FIFO depth in words; power of two, >= 2
//  TIMEOUT  1023  max CLK_Baudin cycles in WAIT_DONE before the word is abandoned
// PORTS
//  CLK_Baudin   in   1               baud-rate clock, shared with the transmitter
//  RstTx        in   1               reset, asynchronous, active-high
//  wr_en        in   1               host write strobe
//  wr_data      in   SIZE            host write word
//  full         out  1               FIFO full
//  empty        out  1               FIFO empty
//  level        out  $clog2(DEPTH)+1 FIFO occupancy
//  overflow     out  1               one-cycle pulse: write dropped because FIFO was full
//  NewData      out  1               one-cycle launch strobe to the transmitter
//  DataIn       out  SIZE            word to the transmitter; stable from NewData until word end
//  DoneTx       in   1               transmitter done level
//  Flag_in      in   1               receiver error flag; indicates a retransmission
//  busy         out  1               a word is in flight (state != IDLE)
//  timeout_err  out  1               one-cycle pulse: watchdog expired, word dropped
// BEHAVIOUR
//  Reset (async): NewData=0, DataIn=0, full=0, empty=1, level=0, overflow=0, busy=0, timeout_err=0.
//   FIFO pointers clear, FSM goes to IDLE, DoneTx edge register clears to 0, watchdog clears.
//  Reset mid-word abandons the in-flight word and discards FIFO contents; no strobe is issued.
//  FIFO write:
//   - Accepted when wr_en=1 and full=0, where full is evaluated before any same-cycle pop.
//   - A write while full is dropped and pulses overflow for one cycle. FIFO contents are unchanged.
//   - A simultaneous push and pop on a non-full FIFO leaves level unchanged.
//   - Pointers wrap modulo DEPTH; the extra level bit distinguishes full from empty.
//  FSM (state in the package):
//   IDLE:
//    - If not empty: pop the head word into DataIn, assert NewData for 1 cycle, go to WAIT_DONE.
//    - Latency: a word written at edge t into an empty FIFO produces NewData=1 during the cycle after edge t+1.
//   WAIT_DONE:
//    - NewData=0; DataIn held.
//    - Watchdog counts up each cycle.
//    - On DoneTx rising edge (DoneTx & ~DoneTx_q): go to GAP.
//    - If the watchdog reaches TIMEOUT first: pulse timeout_err, go to GAP.
//    - If the DoneTx edge and the timeout occur in the same cycle, the DoneTx edge wins and no error is raised.
//    - Flag_in pulses do not change state; the transmitter retries on its own.
//   GAP:
//    - One guard cycle; clear the watchdog, return to IDLE.
//    - Guarantees the transmitter has re-entered its IDLE before the next NewData.
//  The minimum spacing between consecutive NewData strobes is therefore DoneTx edge + 2 cycles.
//  DataIn keeps its last value in IDLE; it is not zeroed after a word.
// CONFIGURATION
//  Macro UART_TX_FEEDER_STATS_EN:
//   - Defined: adds outputs tx_count[15:0] and retry_count[15:0].
//     tx_count increments on each DoneTx edge in WAIT_DONE.
//     retry_count increments on each Flag_in rising edge in WAIT_DONE.
//     Both saturate at 16'hFFFF and reset to 0.
//   - Undefined: these ports and their logic are absent; all other behaviour is identical.
// STRUCTURE
//  Package uart_pkg:
//   - typedef feeder_state_t {IDLE, WAIT_DONE, GAP}.
//   - Constants UART_SIZE=32, FEEDER_DEPTH=8, FEEDER_TIMEOUT=1023.
//  Sub-module uart_sync_fifo (SIZE, DEPTH):
//   - Ports: wr_en/wr_data/rd_en/rd_data/full/empty/level/overflow.
//   - Data is available on rd_data in the same cycle (show-ahead).
//  Top level: FSM, DoneTx/Flag_in edge registers, watchdog, optional stats counters.
// TESTING
//  1. Assert RstTx -> NewData=0, DataIn=0, empty=1, full=0, level=0, busy=0.
//  2. Write 32'hA5A5_0001 while idle -> NewData high for exactly 1 cycle, 2 cycles after the write; DataIn=32'hA5A5_0001.
//     Raise DoneTx 35 cycles later -> busy=0 two cycles after the edge; empty=1.
//  3. Write 9 words back-to-back (0..8) with DoneTx held low -> the first word launches.
//     Then level=8 and full=1 after the 9th write attempt, with no overflow.
//     A 10th write gives an overflow pulse and level stays 8.
//     Words launch in order 0,1,...,8 as DoneTx edges arrive.
//  4. Pulse Flag_in twice during WAIT_DONE, then raise DoneTx -> exactly one NewData for the word.
//     With STATS_EN: retry_count=2, tx_count=1.
//  5. Hold DoneTx low with 2 words queued -> timeout_err pulses at cycle 1023 of WAIT_DONE.
//     The second word gets NewData 2 cycles later.
//  6. Assert RstTx mid-WAIT_DONE with 3 words queued -> outputs reset immediately, level=0.
//     No NewData follows after release.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encoding and default sizing for the UART transmit path.
package uart_pkg;

  localparam int UART_SIZE      = 32;
  localparam int FEEDER_DEPTH   = 8;
  localparam int FEEDER_TIMEOUT = 1023;

  typedef logic [1:0] feeder_state_t;

  localparam feeder_state_t IDLE      = 2'd0;
  localparam feeder_state_t WAIT_DONE = 2'd1;
  localparam feeder_state_t GAP       = 2'd2;

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: show-ahead synchronous FIFO. The head word is visible on rd_data while not empty;
// full is judged before a same-cycle pop, so a write into a full FIFO is always dropped.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int SIZE  = UART_SIZE,
  parameter int DEPTH = FEEDER_DEPTH
) (
  input  logic                   CLK_Baudin,
  input  logic                   RstTx,
  input  logic                   wr_en,
  input  logic [SIZE-1:0]        wr_data,
  input  logic                   rd_en,
  output logic [SIZE-1:0]        rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [SIZE-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   level_q, level_d;
  logic             overflow_q, overflow_d;
  logic             push, pop;

  assign full     = (level_q == (PTR_W+1)'(DEPTH));
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign overflow = overflow_q;
  assign rd_data  = mem_q[rd_ptr_q];

  always_comb begin
    push       = wr_en & ~full;
    pop        = rd_en & ~empty;
    overflow_d = wr_en & full;
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d    = level_q;
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push) begin
      level_d = level_q - 1'b1;
    end
  end

  // Storage needs no reset: nothing is read until a push has written the slot.
  always_ff @(posedge CLK_Baudin) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge CLK_Baudin or posedge RstTx) begin
    if (RstTx) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: buffers host words and launches them one at a time into the UART transmitter.
// Build option UART_TX_FEEDER_STATS_EN adds saturating tx_count / retry_count outputs.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int SIZE    = UART_SIZE,
  parameter int DEPTH   = FEEDER_DEPTH,
  parameter int TIMEOUT = FEEDER_TIMEOUT
) (
  input  logic                   CLK_Baudin,
  input  logic                   RstTx,
  input  logic                   wr_en,
  input  logic [SIZE-1:0]        wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   NewData,
  output logic [SIZE-1:0]        DataIn,
  input  logic                   DoneTx,
  input  logic                   Flag_in,
  output logic                   busy,
  output logic                   timeout_err
`ifdef UART_TX_FEEDER_STATS_EN
  ,output logic [15:0]           tx_count
  ,output logic [15:0]           retry_count
`endif
);

  // state     | meaning
  // IDLE      | no word in flight; pops the FIFO head when one is available
  // WAIT_DONE | word launched, waiting for the DoneTx rising edge or the watchdog
  // GAP       | one guard cycle so the transmitter is back in its idle before the next launch

  localparam int WDOG_W = $clog2(TIMEOUT + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  feeder_state_t     state_q, state_d;
  logic              new_data_q, new_data_d;
  logic [SIZE-1:0]   data_in_q, data_in_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              timeout_q, timeout_d;
  logic              done_tx_q;
  logic              done_edge;
  logic              fifo_pop;
  logic [SIZE-1:0]   fifo_rd_data;

  uart_sync_fifo #(
    .SIZE  (SIZE),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK_Baudin (CLK_Baudin),
    .RstTx      (RstTx),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .rd_en      (fifo_pop),
    .rd_data    (fifo_rd_data),
    .full       (full),
    .empty      (empty),
    .level      (level),
    .overflow   (overflow)
  );

  assign done_edge   = DoneTx & ~done_tx_q;
  assign NewData     = new_data_q;
  assign DataIn      = data_in_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = timeout_q;

  always_comb begin
    state_d    = state_q;
    new_data_d = 1'b0;
    data_in_d  = data_in_q;
    wdog_d     = wdog_q;
    timeout_d  = 1'b0;
    fifo_pop   = 1'b0;
    case (state_q)
      IDLE: begin
        wdog_d = '0;
        if (!empty) begin
          fifo_pop   = 1'b1;
          new_data_d = 1'b1;
          data_in_d  = fifo_rd_data;
          state_d    = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // A completion arriving on the watchdog's last cycle still counts as success.
        if (done_edge) begin
          state_d = GAP;
        end else if (wdog_q == WDOG_LAST) begin
          timeout_d = 1'b1;
          state_d   = GAP;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      GAP: begin
        wdog_d  = '0;
        state_d = IDLE;
      end
      default: begin
        wdog_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK_Baudin or posedge RstTx) begin
    if (RstTx) begin
      state_q    <= IDLE;
      new_data_q <= 1'b0;
      data_in_q  <= '0;
      wdog_q     <= '0;
      timeout_q  <= 1'b0;
      done_tx_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      new_data_q <= new_data_d;
      data_in_q  <= data_in_d;
      wdog_q     <= wdog_d;
      timeout_q  <= timeout_d;
      done_tx_q  <= DoneTx;
    end
  end

`ifdef UART_TX_FEEDER_STATS_EN
  logic        flag_in_q;
  logic [15:0] tx_count_q, tx_count_d;
  logic [15:0] retry_count_q, retry_count_d;

  always_comb begin
    tx_count_d    = tx_count_q;
    retry_count_d = retry_count_q;
    if (state_q == WAIT_DONE) begin
      if (done_edge && (tx_count_q != 16'hFFFF)) begin
        tx_count_d = tx_count_q + 1'b1;
      end
      if (Flag_in && !flag_in_q && (retry_count_q != 16'hFFFF)) begin
        retry_count_d = retry_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_Baudin or posedge RstTx) begin
    if (RstTx) begin
      flag_in_q     <= 1'b0;
      tx_count_q    <= '0;
      retry_count_q <= '0;
    end else begin
      flag_in_q     <= Flag_in;
      tx_count_q    <= tx_count_d;
      retry_count_q <= retry_count_d;
    end
  end

  assign tx_count    = tx_count_q;
  assign retry_count = retry_count_q;
`else
  // Retries are handled entirely by the transmitter; Flag_in only feeds the statistics.
  logic unused_flag_in;
  assign unused_flag_in = Flag_in;
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: table-driven, directed and randomized checks of uart_tx_feeder against a queue-based model.
module tb_uart_tx_feeder;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 1023;

  logic        CLK_Baudin = 1'b0;
  logic        RstTx;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        full, empty, overflow, NewData, busy, timeout_err;
  logic [3:0]  level;
  logic [31:0] DataIn;
  logic        DoneTx, Flag_in;
`ifdef UART_TX_FEEDER_STATS_EN
  logic [15:0] tx_count, retry_count;
`endif

  uart_tx_feeder #(.SIZE(32), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .CLK_Baudin  (CLK_Baudin),
    .RstTx       (RstTx),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .full        (full),
    .empty       (empty),
    .level       (level),
    .overflow    (overflow),
    .NewData     (NewData),
    .DataIn      (DataIn),
    .DoneTx      (DoneTx),
    .Flag_in     (Flag_in),
    .busy        (busy),
    .timeout_err (timeout_err)
`ifdef UART_TX_FEEDER_STATS_EN
    ,.tx_count    (tx_count)
    ,.retry_count (retry_count)
`endif
  );

  always #5 CLK_Baudin = ~CLK_Baudin;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h, required %0h", name, act, req);
    end
  endtask

  // Reference model: a word queue plus "is a word in flight, and for how many cycles".
  localparam int M_IDLE = 0, M_WAIT = 1, M_GUARD = 2;
  logic [31:0] m_q[$];
  int          m_mode, m_waited, m_tx, m_retry;
  bit          m_nd, m_ovf, m_to, m_prev_done, m_prev_flag;
  logic [31:0] m_di;

  task automatic model_reset();
    m_q.delete();
    m_mode = M_IDLE; m_waited = 0; m_tx = 0; m_retry = 0;
    m_nd = 0; m_ovf = 0; m_to = 0; m_prev_done = 0; m_prev_flag = 0;
    m_di = '0;
  endtask

  task automatic model_step();
    bit was_full = (m_q.size() == DEPTH);
    bit d_edge   = DoneTx && !m_prev_done;
    bit f_edge   = Flag_in && !m_prev_flag;
    m_nd = 0; m_ovf = 0; m_to = 0;
    if (m_mode == M_IDLE) begin
      if (m_q.size() != 0) begin
        m_di = m_q.pop_front();
        m_nd = 1; m_mode = M_WAIT; m_waited = 0;
      end
    end else if (m_mode == M_WAIT) begin
      m_waited++;
      if (f_edge && m_retry < 16'hFFFF) m_retry++;
      if (d_edge) begin
        m_mode = M_GUARD;
        if (m_tx < 16'hFFFF) m_tx++;
      end else if (m_waited == TIMEOUT) begin
        m_to = 1; m_mode = M_GUARD;
      end
    end else begin
      m_mode = M_IDLE;
    end
    if (wr_en) begin
      if (was_full) m_ovf = 1;
      else m_q.push_back(wr_data);
    end
    m_prev_done = DoneTx;
    m_prev_flag = Flag_in;
  endtask

  task automatic compare_all();
    chk("NewData", NewData, m_nd);
    chk("DataIn", DataIn, m_di);
    chk("level", level, m_q.size());
    chk("full", full, m_q.size() == DEPTH);
    chk("empty", empty, m_q.size() == 0);
    chk("overflow", overflow, m_ovf);
    chk("busy", busy, m_mode != M_IDLE);
    chk("timeout_err", timeout_err, m_to);
`ifdef UART_TX_FEEDER_STATS_EN
    chk("tx_count", tx_count, m_tx);
    chk("retry_count", retry_count, m_retry);
`endif
  endtask

  // One clock: model consumes current inputs, DUT clocks, outputs compared 1 time unit later.
  task automatic cycle();
    model_step();
    @(posedge CLK_Baudin);
    #1;
    compare_all();
  endtask

  task automatic wait_nd(input string name, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      cycle();
      if (NewData) seen = 1;
    end
    chk(name, seen, 1'b1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      cycle();
      if (!busy) seen = 1;
    end
    chk(name, seen, 1'b1);
  endtask

  typedef struct packed {
    logic [7:0]  reps;
    logic        wr;
    logic [31:0] data;
    logic        done;
    logic        flag;
    logic        exp_nd;
    logic [31:0] exp_di;
    logic [3:0]  exp_lvl;
    logic        exp_busy;
    logic        exp_full;
    logic        exp_ovf;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int nd_cnt, cnt;
    bit found;
`ifdef UART_TX_FEEDER_STATS_EN
    logic [15:0] r0, t0;
`endif

    RstTx = 1'b1; wr_en = 1'b0; wr_data = '0; DoneTx = 1'b0; Flag_in = 1'b0;
    model_reset();

    // Reset values
    repeat (2) @(posedge CLK_Baudin);
    #1;
    chk("rst_NewData", NewData, 1'b0);
    chk("rst_DataIn", DataIn, 32'h0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_level", level, 4'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_timeout", timeout_err, 1'b0);
    RstTx = 1'b0;

    // Single word latency / hold / DoneTx completion, then fill to full and overflow.
    tbl.push_back('{8'd1,  1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0, 32'h0,          4'd1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{8'd1,  1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'hA5A5_0001, 4'd0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{8'd34, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'hA5A5_0001, 4'd0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{8'd1,  1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'hA5A5_0001, 4'd0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{8'd1,  1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'hA5A5_0001, 4'd0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{8'd1,  1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'hA5A5_0001, 4'd0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{8'd1,  1'b1, 32'd0,         1'b0, 1'b0, 1'b0, 32'hA5A5_0001, 4'd1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{8'd1,  1'b1, 32'd1,         1'b0, 1'b0, 1'b1, 32'd0,         4'd1, 1'b1, 1'b0, 1'b0});
    for (int i = 2; i <= 8; i++)
      tbl.push_back('{8'd1, 1'b1, 32'(i), 1'b0, 1'b0, 1'b0, 32'd0, 4'(i), 1'b1, (i == 8), 1'b0});
    tbl.push_back('{8'd1,  1'b1, 32'd9,         1'b0, 1'b0, 1'b0, 32'd0,         4'd8, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{8'd1,  1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'd0,         4'd8, 1'b1, 1'b1, 1'b0});

    for (int r = 0; r < tbl.size(); r++) begin
      wr_en = tbl[r].wr; wr_data = tbl[r].data; DoneTx = tbl[r].done; Flag_in = tbl[r].flag;
      repeat (int'(tbl[r].reps)) cycle();
      chk($sformatf("tbl%0d_nd", r), NewData, tbl[r].exp_nd);
      chk($sformatf("tbl%0d_di", r), DataIn, tbl[r].exp_di);
      chk($sformatf("tbl%0d_lvl", r), level, tbl[r].exp_lvl);
      chk($sformatf("tbl%0d_empty", r), empty, tbl[r].exp_lvl == 4'd0);
      chk($sformatf("tbl%0d_busy", r), busy, tbl[r].exp_busy);
      chk($sformatf("tbl%0d_full", r), full, tbl[r].exp_full);
      chk($sformatf("tbl%0d_ovf", r), overflow, tbl[r].exp_ovf);
    end
    wr_en = 1'b0;

    // Queued words launch in order 1..8 as DoneTx edges arrive.
    for (int k = 1; k <= 8; k++) begin
      DoneTx = 1'b1; cycle(); DoneTx = 1'b0;
      wait_nd($sformatf("drain%0d_nd", k), 8);
      chk($sformatf("drain%0d_data", k), DataIn, 32'(k));
    end
    DoneTx = 1'b1; cycle(); DoneTx = 1'b0;
    wait_idle("drain_idle", 8);
    chk("drain_empty", empty, 1'b1);

    // Flag_in retries do not relaunch the word.
`ifdef UART_TX_FEEDER_STATS_EN
    r0 = retry_count; t0 = tx_count;
`endif
    wr_en = 1'b1; wr_data = 32'h0BAD_F00D; cycle(); wr_en = 1'b0;
    wait_nd("t4_nd", 5);
    nd_cnt = 1;
    Flag_in = 1'b1; cycle(); Flag_in = 1'b0; cycle();
    Flag_in = 1'b1; cycle(); Flag_in = 1'b0; repeat (3) cycle();
    DoneTx = 1'b1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle(); DoneTx = 1'b0;
      if (NewData) nd_cnt++;
      if (!busy) found = 1;
    end
    chk("t4_idle", found, 1'b1);
    chk("t4_nd_count", nd_cnt, 1);
`ifdef UART_TX_FEEDER_STATS_EN
    chk("t4_retry_delta", retry_count - r0, 16'd2);
    chk("t4_tx_delta", tx_count - t0, 16'd1);
`endif

    // Watchdog expiry with a second word queued.
    wr_en = 1'b1; wr_data = 32'h5555_0001; cycle(); wr_en = 1'b0;
    wait_nd("t5_nd", 5);
    wr_en = 1'b1; wr_data = 32'h6666_0002; cycle(); wr_en = 1'b0;
    cnt = 1; found = 0;
    for (int i = 0; i < 1100 && !found; i++) begin
      cycle(); cnt++;
      if (timeout_err) found = 1;
    end
    chk("t5_timeout_seen", found, 1'b1);
    chk("t5_timeout_cycle", cnt, TIMEOUT);
    cycle(); cycle();
    chk("t5_second_nd", NewData, 1'b1);
    chk("t5_second_data", DataIn, 32'h6666_0002);
    DoneTx = 1'b1; cycle(); DoneTx = 1'b0;
    wait_idle("t5_idle", 8);

    // DoneTx edge on the watchdog's final cycle wins over the timeout.
    wr_en = 1'b1; wr_data = 32'h7777_0003; cycle(); wr_en = 1'b0;
    wait_nd("tie_nd", 5);
    repeat (TIMEOUT - 1) cycle();
    DoneTx = 1'b1; cycle(); DoneTx = 1'b0;
    chk("tie_no_timeout", timeout_err, 1'b0);
    chk("tie_guard_busy", busy, 1'b1);
    cycle();
    chk("tie_idle", busy, 1'b0);
    chk("tie_no_late_timeout", timeout_err, 1'b0);

    // Reset mid-word with three words queued.
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 32'hC0DE_0000 + 32'(i); cycle();
    end
    wr_en = 1'b0;
    cycle(); cycle();
    chk("t6_pre_level", level, 4'd3);
    #2 RstTx = 1'b1;
    #1;
    chk("t6_rst_nd", NewData, 1'b0);
    chk("t6_rst_di", DataIn, 32'h0);
    chk("t6_rst_level", level, 4'd0);
    chk("t6_rst_empty", empty, 1'b1);
    chk("t6_rst_busy", busy, 1'b0);
    model_reset();
    @(posedge CLK_Baudin);
    #1;
    RstTx = 1'b0;
    nd_cnt = 0;
    repeat (20) begin
      cycle();
      if (NewData) nd_cnt++;
    end
    chk("t6_no_nd", nd_cnt, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_data = $urandom;
      DoneTx  = ($urandom_range(0, 4) == 0);
      Flag_in = ($urandom_range(0, 6) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
